// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the write-back arbiter
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LONG
  } wb_src_t;

  // One-hot mask for a register address, used by the pending scoreboard.
  function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_ADDR_W-1:0] r);
    regMask = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of write-back entries for long-latency results
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  wb_entry_t     pushEntry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_entry_t   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter merging ALU and long-latency results
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  AluValid,
  input  logic [REG_ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0]     AluData,
  output logic                  AluStall,
  input  logic                  LongIssue,
  input  logic [REG_ADDR_W-1:0] LongIssueReg,
  input  logic                  LongValid,
  input  logic [REG_ADDR_W-1:0] LongRetReg,
  input  logic [DATA_W-1:0]     LongRetData,
  output logic                  LongReady,
  output logic                  RegWre,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  output logic [NUM_REGS-1:0]   Pending,
  output logic                  WawErr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_entry_t     fifoHead;
  wb_entry_t     pushEntry;
  logic [CW-1:0] fifoCount;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          pushFifo;
  logic          popFifo;

  wb_src_t             src;
  logic [SW-1:0]       starveCnt;
  logic [SW-1:0]       starveNext;
  logic [NUM_REGS-1:0] pendingNext;

  assign pushEntry = '{dest: LongRetReg, data: LongRetData};
  assign pushFifo  = LongValid && !fifoFull && (LongRetReg != '0);
  assign LongReady = (fifoCount < CW'(DEPTH));
  assign popFifo   = (src == WB_LONG);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (pushFifo),
    .pushEntry (pushEntry),
    .pop       (popFifo),
    .head      (fifoHead),
    .count     (fifoCount),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  // A starved FIFO head preempts the ALU; otherwise the ALU has priority.
  always_comb begin
    src      = WB_NONE;
    AluStall = 1'b0;
    if (!fifoEmpty && starveCnt == STARVE_LIM) begin
      src      = WB_LONG;
      AluStall = AluValid;
    end else if (AluValid && AluReg != '0) begin
      src = WB_ALU;
    end else if (!fifoEmpty) begin
      src = WB_LONG;
    end
  end

  always_comb begin
    starveNext = starveCnt;
    if (fifoEmpty || popFifo) begin
      starveNext = '0;
    end else if (src == WB_ALU && starveCnt != STARVE_LIM) begin
      starveNext = starveCnt + SW'(1);
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    pendingNext = Pending;
    if (popFifo) pendingNext = pendingNext & ~regMask(fifoHead.dest);
    if (LongIssue && LongIssueReg != '0) pendingNext = pendingNext | regMask(LongIssueReg);
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      starveCnt <= '0;
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      Pending   <= '0;
      WawErr    <= 1'b0;
    end else begin
      starveCnt <= starveNext;
      Pending   <= pendingNext;
      RegWre    <= (src != WB_NONE);
      if (src == WB_ALU) begin
        WriteReg  <= AluReg;
        WriteData <= AluData;
        if (Pending[AluReg]) WawErr <= 1'b1;
      end else if (src == WB_LONG) begin
        WriteReg  <= fifoHead.dest;
        WriteData <= fifoHead.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed scoreboard bench for wb_arbiter
module tb_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        AluStall;
  logic        LongIssue;
  logic [4:0]  LongIssueReg;
  logic        LongValid;
  logic [4:0]  LongRetReg;
  logic [31:0] LongRetData;
  logic        LongReady;
  logic        RegWre;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] Pending;
  logic        WawErr;

  int checks = 0;
  int failures = 0;
  logic [36:0] expQ[$];

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .AluValid     (AluValid),
    .AluReg       (AluReg),
    .AluData      (AluData),
    .AluStall     (AluStall),
    .LongIssue    (LongIssue),
    .LongIssueReg (LongIssueReg),
    .LongValid    (LongValid),
    .LongRetReg   (LongRetReg),
    .LongRetData  (LongRetData),
    .LongReady    (LongReady),
    .RegWre       (RegWre),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .Pending      (Pending),
    .WawErr       (WawErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then retire any register-file write against the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge CLK);
    #1;
    if (RegWre === 1'b1) begin
      checks++;
      assert (expQ.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed reg=%0d data=%0h expected=no write", WriteReg, WriteData);
      end
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("wb_reg", 32'(WriteReg), 32'(e[36:32]));
        chk("wb_data", WriteData, e[31:0]);
      end
    end
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
    expQ.push_back({r, d});
  endtask

  initial begin
    RST = 1'b0; AluValid = 1'b0; AluReg = '0; AluData = '0;
    LongIssue = 1'b0; LongIssueReg = '0;
    LongValid = 1'b0; LongRetReg = '0; LongRetData = '0;
    tick();
    tick();
    chk("reset_regwre", 32'(RegWre), 32'd0);
    chk("reset_pending", Pending, 32'd0);
    chk("reset_longready", 32'(LongReady), 32'd1);
    chk("reset_wawerr", 32'(WawErr), 32'd0);
    RST = 1'b1;
    tick();
    chk("idle_regwre", 32'(RegWre), 32'd0);

    // Single ALU write
    AluValid = 1'b1; AluReg = 5'd5; AluData = 32'h1234;
    expect_write(5'd5, 32'h1234);
    tick();
    chk("alu_regwre", 32'(RegWre), 32'd1);
    AluValid = 1'b0;
    tick();
    chk("alu_one_cycle", 32'(RegWre), 32'd0);

    // Long issue then return
    LongIssue = 1'b1; LongIssueReg = 5'd8;
    tick();
    LongIssue = 1'b0;
    chk("pending_set", Pending, 32'h100);
    tick();
    LongValid = 1'b1; LongRetReg = 5'd8; LongRetData = 32'hDEAD;
    expect_write(5'd8, 32'hDEAD);
    tick();
    LongValid = 1'b0;
    chk("push_edge_no_write", 32'(RegWre), 32'd0);
    chk("pending_held", Pending, 32'h100);
    tick();
    chk("pop_edge_write", 32'(RegWre), 32'd1);
    chk("pending_cleared", Pending, 32'd0);

    // Fill FIFO while ALU is busy
    for (int i = 0; i < 4; i++) begin
      AluValid = 1'b1; AluReg = 5'(20 + i); AluData = 32'hA0 + 32'(i);
      LongValid = 1'b1; LongRetReg = 5'(11 + i); LongRetData = 32'hB0 + 32'(i);
      expect_write(AluReg, AluData);
      tick();
    end
    chk("full_longready", 32'(LongReady), 32'd0);
    AluReg = 5'd24; AluData = 32'hA4;
    LongRetReg = 5'd15; LongRetData = 32'hBAD;
    expect_write(5'd24, 32'hA4);
    tick();
    chk("full_still", 32'(LongReady), 32'd0);
    AluValid = 1'b0; LongValid = 1'b0;
    for (int i = 0; i < 4; i++) expect_write(5'(11 + i), 32'hB0 + 32'(i));
    tick();
    chk("drain_write0", 32'(RegWre), 32'd1);
    chk("drain_longready", 32'(LongReady), 32'd1);
    tick();
    tick();
    tick();
    chk("drain_write3", 32'(RegWre), 32'd1);
    tick();
    chk("fifth_dropped", 32'(RegWre), 32'd0);

    // Starvation forcing
    LongValid = 1'b1; LongRetReg = 5'd16; LongRetData = 32'hC0DE;
    tick();
    LongValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      AluValid = 1'b1; AluReg = 5'(21 + k); AluData = 32'h300 + 32'(k);
      chk("no_stall_yet", 32'(AluStall), 32'd0);
      expect_write(AluReg, AluData);
      tick();
    end
    AluReg = 5'd29; AluData = 32'h99;
    chk("starve_stall", 32'(AluStall), 32'd1);
    expect_write(5'd16, 32'hC0DE);
    expect_write(5'd29, 32'h99);
    tick();
    chk("forced_write", 32'(RegWre), 32'd1);
    chk("stall_released", 32'(AluStall), 32'd0);
    tick();
    AluValid = 1'b0;
    tick();
    chk("after_held_alu", 32'(RegWre), 32'd0);

    // r0 writes are discarded
    AluValid = 1'b1; AluReg = 5'd0; AluData = 32'h55;
    LongValid = 1'b1; LongRetReg = 5'd0; LongRetData = 32'h66;
    chk("r0_no_stall", 32'(AluStall), 32'd0);
    tick();
    AluValid = 1'b0; LongValid = 1'b0;
    chk("r0_no_write", 32'(RegWre), 32'd0);
    tick();
    chk("r0_no_push", 32'(RegWre), 32'd0);

    // WAW detection
    LongIssue = 1'b1; LongIssueReg = 5'd9;
    tick();
    LongIssue = 1'b0;
    chk("waw_before", 32'(WawErr), 32'd0);
    AluValid = 1'b1; AluReg = 5'd9; AluData = 32'h77;
    expect_write(5'd9, 32'h77);
    tick();
    AluValid = 1'b0;
    chk("waw_set", 32'(WawErr), 32'd1);
    tick();
    tick();
    chk("waw_sticky", 32'(WawErr), 32'd1);

    // Same-cycle set and clear of one register
    LongIssue = 1'b1; LongIssueReg = 5'd10;
    tick();
    LongIssue = 1'b0;
    LongValid = 1'b1; LongRetReg = 5'd10; LongRetData = 32'hAA;
    expect_write(5'd10, 32'hAA);
    tick();
    LongValid = 1'b0;
    LongIssue = 1'b1; LongIssueReg = 5'd10;
    tick();
    LongIssue = 1'b0;
    chk("setclr_write", 32'(RegWre), 32'd1);
    chk("set_wins", Pending, 32'h600);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      AluValid = 1'b1; AluReg = 5'(25 + i); AluData = 32'h500 + 32'(i);
      LongValid = 1'b1; LongRetReg = 5'(1 + i); LongRetData = 32'h700 + 32'(i);
      LongIssue = (i == 0); LongIssueReg = 5'd3;
      expect_write(AluReg, AluData);
      tick();
    end
    LongIssue = 1'b0;
    AluValid = 1'b0; LongValid = 1'b0;
    RST = 1'b0;
    tick();
    chk("rst_regwre", 32'(RegWre), 32'd0);
    chk("rst_pending", Pending, 32'd0);
    chk("rst_longready", 32'(LongReady), 32'd1);
    chk("rst_wawerr", 32'(WawErr), 32'd0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", 32'(RegWre), 32'd0);
    end
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the MIPS core and the sole driver of the register file write port (RegWre/WriteReg/WriteData). It merges single-cycle ALU/load results with out-of-order results from long-latency units (mult/div) through a small FIFO. It also keeps a pending-destination scoreboard that the hazard unit uses to stall readers of registers that still await a long result.

## Interface
Parameters:
- DEPTH, 4, long-result FIFO entries (power of two, ≥2)
- STARVE_MAX, 8, cycles a FIFO head may wait behind ALU traffic before it is forced through

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- AluValid  in  1  ALU/load result present this cycle
- AluReg  in  5  ALU destination register
- AluData  in  32  ALU result
- AluStall  out  1  combinational; ALU result not accepted this cycle, upstream holds it
- LongIssue  in  1  long-latency op issued this cycle
- LongIssueReg  in  5  its destination register
- LongValid  in  1  long-latency result returning
- LongRetReg  in  5  destination register of returning result
- LongRetData  in  32  returning result
- LongReady  out  1  FIFO can accept; registered, equals count < DEPTH
- RegWre  out  1  register-file write enable, registered
- WriteReg  out  5  register-file write address, registered
- WriteData  out  32  register-file write data, registered
- Pending  out  32  bit r set while a long result for register r is outstanding; bit 0 always 0
- WawErr  out  1  sticky; ALU wrote a register whose Pending bit was set

## Operation
- Push: LongValid && LongReady && LongRetReg != 0 stores {LongRetReg, LongRetData} at the tail. LongValid with LongRetReg == 0 is dropped and clears nothing.
- Selection on each edge, in priority order:
  - If the FIFO is non-empty and starve count == STARVE_MAX, the FIFO head wins and AluStall = AluValid.
  - Otherwise, if AluValid && AluReg != 0, the ALU wins.
  - Otherwise, if the FIFO is non-empty, the head wins.
  - Otherwise RegWre <= 0.
- ALU writes with AluReg == 0 are consumed (AluStall = 0) and produce no write.
- Starve counter:
  - increments each cycle the FIFO is non-empty and the ALU wins
  - resets to 0 on any pop or when the FIFO is empty
  - saturates at STARVE_MAX
- Scoreboard:
  - LongIssue && LongIssueReg != 0 sets Pending[LongIssueReg]
  - a pop clears Pending[WriteReg of the popped entry]
  - same register set and cleared in the same cycle: set wins
- WawErr is set when the ALU wins with Pending[AluReg] = 1. It clears only on reset.
- Reset (RST = 0 at an edge), including mid-operation: FIFO pointers and count 0 (contents discarded), starve count 0, RegWre 0, WriteReg 0, WriteData 0, Pending 0, WawErr 0, LongReady 1.

## Timing
- ALU path: AluValid sampled at edge N; RegWre/WriteReg/WriteData are valid from edge N until edge N+1. The register file commits on the falling edge inside that cycle.
- Long path: push at edge N, earliest pop at edge N+1, so RegWre is high from N+1 to N+2. Minimum latency is 2 edges from LongValid to commit.
- One write per cycle maximum; RegWre is never high for two sources at once.
- Full FIFO: LongReady = 0 and any LongValid is ignored. Simultaneous push and pop with count < DEPTH leaves the count unchanged. LongReady is computed from the registered count only, so a pop does not open space in the same cycle.
- Pointer wrap-around is modulo DEPTH. Count width is clog2(DEPTH)+1.
- Pending clears on the same edge RegWre rises for that entry. A reader stalled on Pending therefore sees the new value by the following cycle through the register file's negedge write.

## Structure
- Package wb_pkg: REG_ADDR_W = 5, DATA_W = 32, wb_entry_t struct {reg[4:0], data[31:0]}, source enum {WB_NONE, WB_ALU, WB_LONG}.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push, pop, head, count, full, empty. wb_arbiter holds the selection, starve counter, scoreboard and output registers.

## Test plan
- Reset then idle: RegWre = 0, Pending = 0, LongReady = 1, WawErr = 0. ALU write r5 = 0x1234 at edge N -> RegWre = 1, WriteReg = 5, WriteData = 0x1234 for exactly one cycle.
- LongIssue r8, then LongValid r8 = 0xDEAD → Pending[8] = 1 until the pop edge. The pop occurs on the edge after the push, with WriteReg = 8 and WriteData = 0xDEAD.
- Push 4 results with no pops (ALU busy) → LongReady = 0; a fifth LongValid is dropped. The results then drain in FIFO order, one per cycle, with correct data.
- Continuous AluValid with a non-empty FIFO → after 8 ALU wins, AluStall = 1 for one cycle and the FIFO head is written. The held ALU result is written the following cycle.
- Writes to r0 from the ALU and from LongValid → no RegWre pulse and no FIFO push. An ALU write to pending r9 → WawErr = 1, sticky until reset.
- RST low mid-drain with 3 entries queued → at the next edge the FIFO is empty, Pending = 0 and RegWre = 0, and no stale entry appears afterwards.
